// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register bank's single write port, with bounded lock bursts.
// All outputs are registered; a grant issued on edge n is visible until edge n+1.
module reg_write_arbiter #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [3:0]          lock,
  input  logic [3:0]          req_clr,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          gnt,
  output logic                wr_en,
  output logic                wr_clr,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data
);

  typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;

  logic [1:0]  rr_win, win;
  logic        rr_found, keep, issue;

  logic [3:0]        gnt_d;
  logic              wr_en_d, wr_clr_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  // Owner keeps the port only while still requesting, still locked and under the burst limit.
  assign keep = (state_q == StLocked) && req[owner_q] && lock[owner_q] &&
                (lock_cnt_q < 4'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      gnt        <= '0;
      wr_en      <= 1'b0;
      wr_clr     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      gnt        <= gnt_d;
      wr_en      <= wr_en_d;
      wr_clr     <= wr_clr_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = StIdle;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    win        = '0;
    issue      = 1'b0;
    rr_win     = '0;
    rr_found   = 1'b0;
    // Scan from lowest to highest priority so the last hit is the first in search order.
    for (int k = 0; k < 4; k++) begin
      if (req[ptr_q + 2'(3 - k)]) begin
        rr_win   = ptr_q + 2'(3 - k);
        rr_found = 1'b1;
      end
    end
    if (keep) begin
      issue      = 1'b1;
      win        = owner_q;
      lock_cnt_d = lock_cnt_q + 4'd1;
      state_d    = StLocked;
    end else if (rr_found) begin
      issue      = 1'b1;
      win        = rr_win;
      ptr_d      = rr_win + 2'd1;
      owner_d    = rr_win;
      lock_cnt_d = 4'd1;
      state_d    = lock[rr_win] ? StLocked : StGrant;
    end else begin
      lock_cnt_d = '0;
    end
  end

  always_comb begin
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_clr_d  = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    if (issue) begin
      gnt_d[win] = 1'b1;
      wr_en_d    = 1'b1;
      wr_clr_d   = req_clr[win];
      wr_addr_d  = req_addr[32'(win)*ADDR_W +: ADDR_W];
      wr_data_d  = req_clr[win] ? '0 : req_data[32'(win)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter sharing the single write port of the register bank between four requesters. Each cycle it picks one requester, registers that requester's address, data and clear request, and drives the bank's write-enable, address, data and clear lines. An optional lock lets a requester keep the port for a bounded burst of writes. It sits between the sequencer and ALU write-back sources and the `myDFF`-based register bank, where `wr_en` feeds the per-bit `enable`.

## Interface
- `DATA_W`, 8, width of register data.
- `ADDR_W`, 3, width of register address (2^ADDR_W registers).
- `MAX_LOCK`, 4, maximum consecutive grants to one locked requester (legal range 1..15).

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `req`  in  4  per-requester write request.
- `lock`  in  4  per-requester burst hold; meaningful only while that requester holds `req`.
- `req_clr`  in  4  per-requester: write the bank reset value instead of data.
- `req_addr`  in  4*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  4*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- `gnt`  out  4  one-hot grant; all zero when idle.
- `wr_en`  out  1  bank write enable.
- `wr_clr`  out  1  bank clear, driving `reset` of the target register with its `rval`.
- `wr_addr`  out  ADDR_W  bank write address.
- `wr_data`  out  DATA_W  bank write data.

## Operation
- All outputs are registered. No combinational path runs from any input to any output.
- State machine:
  - IDLE: no grant is active.
  - GRANT: a single-cycle grant was issued.
  - LOCKED: the current owner holds the port.
- Round-robin pointer `ptr` (2 bits) names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3 mod 4.
- From IDLE or GRANT: if any `req` bit is set, grant the first set bit in search order (call it w).
  - `gnt` = 1<<w; `wr_en` = 1; `wr_addr`, `wr_data`, `wr_clr` = requester w's fields.
  - `ptr` becomes w+1 mod 4.
  - Next state is LOCKED if `lock[w]`, otherwise GRANT. `lock_cnt` becomes 1.
- From IDLE or GRANT with no `req` bit set: all outputs return to zero and the next state is IDLE.
- In LOCKED with owner o:
  - If `req[o]` and `lock[o]` are both set and `lock_cnt` < MAX_LOCK: grant o again with its current fields and increment `lock_cnt`.
  - Otherwise the lock ends and normal round-robin arbitration runs in the same cycle. `ptr` is already o+1, so o has lowest priority. If no `req` bit is set, the next state is IDLE.
- When `lock_cnt` reaches MAX_LOCK, the owner must lose priority for one round even if it still has `lock` set.
- When `req_clr[w]` is set, `wr_clr`=1, `wr_en`=1 and `wr_data`=0.
- A requester drops `req` in the cycle it sees its `gnt` high if it wants only one write. If `req` stays high it is simply re-arbitrated.
- Reset (`reset`=0 at a clock edge) takes priority over everything:
  - `gnt`=0, `wr_en`=0, `wr_clr`=0, `wr_addr`=0, `wr_data`=0.
  - `ptr`=0, `lock_cnt`=0, state IDLE.
  - A reset in the middle of a lock cancels the burst. No write is issued in the reset cycle.

## Timing
- Latency: `req` sampled at edge n gives `gnt`/`wr_*` valid from edge n to edge n+1. The bank captures on edge n+1.
- Throughput is one write per cycle. Back-to-back grants to different requesters are allowed with no idle cycle.
- `req_*` fields are sampled only on the edge that issues the grant. The requester must hold them stable from `req` assertion until that edge.
- `gnt` is always one-hot or zero. `wr_en` equals OR(`gnt`) at all times.
- `lock` is ignored for requesters that are not granted. Asserting `lock` without `req` has no effect.
- The first cycle after reset release behaves as IDLE, with requester 0 at highest priority.

## Test plan
- Reset and idle:
  - Hold `reset`=0 for 2 cycles with all `req`=4'b1111.
  - Required: all outputs 0. On the first edge after release, `gnt`=4'b0001.
- Round-robin fairness:
  - `req`=4'b1111 held for 8 cycles, `lock`=0.
  - Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
  - Required: `wr_addr`/`wr_data` match each winner's fields, e.g. requester 2 with addr 3'd5, data 8'hA5 gives `wr_addr`=5, `wr_data`=8'hA5.
- Lock burst and limit:
  - `req`=4'b0011, `lock`=4'b0001, MAX_LOCK=4.
  - Required: `gnt`=0001 for 4 consecutive cycles, then 0010, then 0001 again.
- Early lock release:
  - Requester 1 locked; drop `lock[1]` after 2 grants while `req`=4'b0110.
  - Required: the next grant is 0100. No cycle is lost.
- Clear request:
  - `req`=4'b1000, `req_clr`=4'b1000, addr 3'd7, data 8'hFF.
  - Required: `wr_en`=1, `wr_clr`=1, `wr_addr`=7, `wr_data`=0.
- Reset mid-lock:
  - Assert `reset`=0 during the 2nd cycle of a locked burst by requester 3.
  - Required: all outputs 0 next cycle. After release with `req`=4'b1001, the first grant is 0001 (`ptr` reset to 0).
